// File: rtl/gpu_pipe_pkg.sv
// rtl/gpu_pipe_pkg.sv - shared state type and default strides for the triangle pipeline sequencer
package gpu_pipe_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pipe_state_t;

  localparam int DEFAULT_VERTEX_STRIDE = 18;
  localparam int DEFAULT_COLOR_STRIDE  = 2;

endpackage

// File: rtl/pipe_sequencer_if.sv
// rtl/pipe_sequencer_if.sv - frame-controller and stage control signals of pipe_sequencer
interface pipe_sequencer_if #(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32,
  parameter int STAGES      = 3
);

  logic [ADDR_WIDTH-1:0]  base_addr_vertex;
  logic [ADDR_WIDTH-1:0]  base_addr_color;
  logic [COUNT_WIDTH-1:0] triangles_count;
  logic                   frame_start;
  logic                   abort;
  logic                   frame_busy;
  logic                   frame_end;
  logic [STAGES-1:0]      stage_start;
  logic [STAGES-1:0]      stage_done;
  logic [STAGES-1:0]      stage_valid;
  logic [ADDR_WIDTH-1:0]  addr_vertex;
  logic [ADDR_WIDTH-1:0]  addr_color;
  logic [COUNT_WIDTH-1:0] stall_cycles;

  modport master (
    input  base_addr_vertex, base_addr_color, triangles_count, frame_start, abort, stage_done,
    output frame_busy, frame_end, stage_start, stage_valid, addr_vertex, addr_color, stall_cycles
  );

  modport slave (
    output base_addr_vertex, base_addr_color, triangles_count, frame_start, abort, stage_done,
    input  frame_busy, frame_end, stage_start, stage_valid, addr_vertex, addr_color, stall_cycles
  );

endinterface

// File: rtl/pipe_sequencer_stage_tracker.sv
// rtl/pipe_sequencer_stage_tracker.sv - per-stage occupancy and completion tracking
module stage_tracker (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic advance,
  input  logic valid_in,
  input  logic stage_done,
  output logic stage_valid,
  output logic ready
);

  logic done_seen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_valid <= 1'b0;
      done_seen   <= 1'b0;
    end else if (clear) begin
      stage_valid <= 1'b0;
      done_seen   <= 1'b0;
    end else if (advance) begin
      stage_valid <= valid_in;
      done_seen   <= 1'b0;
    end else if (stage_valid && stage_done) begin
      done_seen <= 1'b1;
    end
  end

  // A done arriving in the advance cycle itself already counts.
  assign ready = !stage_valid || done_seen || stage_done;

endmodule

// File: rtl/pipe_sequencer.sv
// rtl/pipe_sequencer.sv - lock-step triangle pipeline sequencer; PIPE_STATS_EN adds the stall counter
module pipe_sequencer
  import gpu_pipe_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int COUNT_WIDTH   = 32,
  parameter int STAGES        = 3,
  parameter int VERTEX_STRIDE = DEFAULT_VERTEX_STRIDE,
  parameter int COLOR_STRIDE  = DEFAULT_COLOR_STRIDE
) (
  input logic              clk,
  input logic              reset_n,
  pipe_sequencer_if.master bus
);

  pipe_state_t            state;
  pipe_state_t            state_next;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] issued;
  logic [ADDR_WIDTH-1:0]  addr_vertex_q;
  logic [ADDR_WIDTH-1:0]  addr_color_q;
  logic                   frame_end_q;
  logic [STAGES-1:0]      valid_q;
  logic [STAGES-1:0]      valid_next;
  logic [STAGES-1:0]      ready;
  logic                   run;
  logic                   accept;
  logic                   advance;
  logic                   issue;
  logic                   drain_done;

  assign run        = (state == RUN);
  assign accept     = !run && bus.frame_start && !bus.abort;
  assign advance    = run && !bus.abort && (&ready);
  assign issue      = advance && (issued < count_q);
  assign drain_done = advance && (valid_next == '0) && (issued == count_q);

  genvar g;
  for (g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign valid_next[g] = issue;
    end else begin : g_body
      assign valid_next[g] = valid_q[g-1];
    end

    stage_tracker u_tracker (
      .clk         (clk),
      .reset_n     (reset_n),
      .clear       (bus.abort),
      .advance     (advance),
      .valid_in    (valid_next[g]),
      .stage_done  (bus.stage_done[g]),
      .stage_valid (valid_q[g]),
      .ready       (ready[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (bus.abort || drain_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q       <= '0;
      issued        <= '0;
      addr_vertex_q <= '0;
      addr_color_q  <= '0;
      frame_end_q   <= 1'b0;
    end else begin
      frame_end_q <= drain_done;
      if (accept) begin
        count_q       <= bus.triangles_count;
        issued        <= '0;
        addr_vertex_q <= bus.base_addr_vertex;
        addr_color_q  <= bus.base_addr_color;
      end else if (bus.abort) begin
        issued <= '0;
      end else if (issue) begin
        // The current address was presented with this issue; step to the next triangle.
        issued        <= issued + COUNT_WIDTH'(1);
        addr_vertex_q <= addr_vertex_q + ADDR_WIDTH'(VERTEX_STRIDE);
        addr_color_q  <= addr_color_q + ADDR_WIDTH'(COLOR_STRIDE);
      end
    end
  end

`ifdef PIPE_STATS_EN
  logic [COUNT_WIDTH-1:0] stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (run && !advance && (stall_q != '1)) begin
      stall_q <= stall_q + COUNT_WIDTH'(1);
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.frame_busy  = run;
  assign bus.frame_end   = frame_end_q;
  assign bus.stage_start = advance ? valid_next : '0;
  assign bus.stage_valid = valid_q;
  assign bus.addr_vertex = addr_vertex_q;
  assign bus.addr_color  = addr_color_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// tb/tb_pipe_sequencer.sv - directed table-driven bench for pipe_sequencer
module tb_pipe_sequencer;
  import gpu_pipe_pkg::*;

  localparam int AW = 32;
  localparam int CW = 32;
  localparam int NS = 3;

  typedef struct {
    int          cnt;
    logic [31:0] bv;
    logic [31:0] bc;
    int          slow;
    int          dly;
    bit          poke;
    int          exp_end;
    int          exp_stall;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pipe_sequencer_if #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .STAGES(NS)) bus_if ();

  pipe_sequencer #(.ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .STAGES(NS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t0 = 0;
  int delay [NS];
  int due [NS];
  bit pending [NS];
  int starts_total [NS];
  logic [NS-1:0] done_next = '0;
  logic [NS-1:0] hist [64];
  logic [31:0] obs_v [256];
  logic [31:0] obs_c [256];
  int obs_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stage model: done arrives 1+delay cycles after each start; applied just after the edge.
  always @(negedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (bus_if.stage_start[i]) begin
        pending[i] = 1'b1;
        due[i] = cyc + 1 + delay[i];
        starts_total[i]++;
      end
      done_next[i] = pending[i] && (due[i] == cyc + 1);
      if (done_next[i]) pending[i] = 1'b0;
    end
    if (bus_if.stage_start[0] && obs_n < 256) begin
      obs_v[obs_n] = bus_if.addr_vertex;
      obs_c[obs_n] = bus_if.addr_color;
      obs_n++;
    end
    if (cyc - t0 >= 0 && cyc - t0 < 64) hist[cyc - t0] = bus_if.stage_start;
  end

  always @(posedge clk) begin
    #1;
    bus_if.stage_done = done_next;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input vec_t v, input int vi);
    int s0 [NS];
    int k0;
    int end_off;
    string tag;
    logic [31:0] ev;
    logic [31:0] ec;
    @(posedge clk);
    #2;
    for (int i = 0; i < NS; i++) begin
      delay[i] = (i == v.slow) ? v.dly : 0;
      s0[i] = starts_total[i];
    end
    k0 = obs_n;
    @(negedge clk);
    t0 = cyc;
    bus_if.base_addr_vertex = v.bv;
    bus_if.base_addr_color = v.bc;
    bus_if.triangles_count = v.cnt;
    bus_if.frame_start = 1'b1;
    @(negedge clk);
    bus_if.frame_start = 1'b0;
    end_off = -1;
    for (int n = 1; n < 300; n++) begin
      if (v.poke && n == 2) begin
        bus_if.frame_start = 1'b1;
        bus_if.triangles_count = 9;
        bus_if.base_addr_vertex = 32'h9999;
      end else begin
        bus_if.frame_start = 1'b0;
      end
      if (bus_if.frame_end) begin
        end_off = cyc - t0;
        break;
      end
      @(negedge clk);
    end
    bus_if.frame_start = 1'b0;
    tag = $sformatf("v%0d", vi);
    check({tag, " frame_end_cycle"}, end_off, v.exp_end);
    check({tag, " busy_at_end"}, bus_if.frame_busy, 0);
`ifdef PIPE_STATS_EN
    check({tag, " stall_cycles"}, bus_if.stall_cycles, v.exp_stall);
`else
    check({tag, " stall_cycles"}, bus_if.stall_cycles, 0);
`endif
    for (int i = 0; i < NS; i++)
      check($sformatf("%s starts_stage%0d", tag, i), starts_total[i] - s0[i], v.cnt);
    for (int j = 0; j < v.cnt && k0 + j < 256; j++) begin
      ev = v.bv + 32'(j * 18);
      ec = v.bc + 32'(j * 2);
      check($sformatf("%s addr_vertex%0d", tag, j), obs_v[k0 + j], ev);
      check($sformatf("%s addr_color%0d", tag, j), obs_c[k0 + j], ec);
    end
    @(negedge clk);
    check({tag, " frame_end_pulse_width"}, bus_if.frame_end, 0);
  endtask

  vec_t vecs [6];
  bit seen_end;

  initial begin
    vecs[0] = '{1, 32'h100, 32'h200, -1, 0, 1'b0, 5, 0};
    vecs[1] = '{3, 32'h1000, 32'h2000, -1, 0, 1'b0, 7, 0};
    vecs[2] = '{0, 32'hA0, 32'hB0, -1, 0, 1'b0, 2, 0};
    vecs[3] = '{4, 32'h10, 32'h20, 1, 3, 1'b0, 20, 12};
    vecs[4] = '{1, 32'h0, 32'h0, 2, 5, 1'b0, 10, 5};
    vecs[5] = '{2, 32'hFFFF_FFF0, 32'hFFFF_FFFF, -1, 0, 1'b1, 6, 0};

    for (int i = 0; i < NS; i++) begin
      delay[i] = 0;
      due[i] = 0;
      pending[i] = 1'b0;
      starts_total[i] = 0;
    end
    bus_if.base_addr_vertex = '0;
    bus_if.base_addr_color = '0;
    bus_if.triangles_count = '0;
    bus_if.frame_start = 1'b0;
    bus_if.abort = 1'b0;

    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset frame_busy", bus_if.frame_busy, 0);
    check("reset frame_end", bus_if.frame_end, 0);
    check("reset stage_start", bus_if.stage_start, 0);
    check("reset stage_valid", bus_if.stage_valid, 0);
    check("reset addr_vertex", bus_if.addr_vertex, 0);
    check("reset addr_color", bus_if.addr_color, 0);
    check("reset stall_cycles", bus_if.stall_cycles, 0);
    reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v], v);
      if (v == 0) begin
        check("v0 start_pattern_t1", hist[1], 3'b001);
        check("v0 start_pattern_t2", hist[2], 3'b010);
        check("v0 start_pattern_t3", hist[3], 3'b100);
        check("v0 start_pattern_t4", hist[4], 3'b000);
      end
    end

    // Abort mid-frame while stage 0 reports done, then restart from a new base.
    @(posedge clk);
    #2;
    for (int i = 0; i < NS; i++) delay[i] = 0;
    bus_if.base_addr_vertex = 32'h3000;
    bus_if.base_addr_color = 32'h3100;
    bus_if.triangles_count = 4;
    bus_if.frame_start = 1'b1;
    @(posedge clk);
    #2;
    bus_if.frame_start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("abort pre_stage_valid", bus_if.stage_valid, 3'b011);
    bus_if.abort = 1'b1;
    #1;
    check("abort stage_start_suppressed", bus_if.stage_start, 0);
    @(posedge clk);
    #2;
    bus_if.abort = 1'b0;
    check("abort busy_next", bus_if.frame_busy, 0);
    check("abort stage_valid_next", bus_if.stage_valid, 0);
    seen_end = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus_if.frame_end) seen_end = 1'b1;
    end
    check("abort no_frame_end", seen_end, 0);
    run_frame('{2, 32'h4000, 32'h5000, -1, 0, 1'b0, 6, 0}, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_sequencer.md
# pipe_sequencer

Frame-level sequencer for the triangle rendering pipeline, generalised to STAGES lock-step stages with real fill and drain. It issues triangles into stage 0, tracks per-stage occupancy, advances all stages together once every occupied stage has reported completion, and generates fetch addresses. It signals frame completion only after the last triangle leaves the final stage. It sits between the frame controller and the fetch/vertex/pixel compute units and carries control only: each stage latches its own payload on its `stage_start`.

## Interface
- `ADDR_WIDTH`, 32, address width
- `COUNT_WIDTH`, 32, triangle count / counter width
- `STAGES`, 3, number of pipeline stages (≥1); stage 0 is fetch
- `VERTEX_STRIDE`, 18, byte increment of vertex address per triangle
- `COLOR_STRIDE`, 2, byte increment of color address per triangle
- `clk`  in  1  clock
- `reset_n`  in  1  asynchronous, active-low reset
- `base_addr_vertex`  in  ADDR_WIDTH  vertex buffer base, sampled on accepted `frame_start`
- `base_addr_color`  in  ADDR_WIDTH  color buffer base, sampled on accepted `frame_start`
- `triangles_count`  in  COUNT_WIDTH  triangles in frame, sampled on accepted `frame_start`
- `frame_start`  in  1  start pulse, accepted only in IDLE
- `abort`  in  1  synchronous frame cancel
- `frame_busy`  out  1  high while state ≠ IDLE
- `frame_end`  out  1  one-cycle completion pulse, registered
- `stage_start`  out  STAGES  per-stage start pulse, combinational
- `stage_done`  in  STAGES  per-stage completion pulse
- `stage_valid`  out  STAGES  occupancy register
- `addr_vertex`  out  ADDR_WIDTH  vertex address of the triangle being issued
- `addr_color`  out  ADDR_WIDTH  color address of the triangle being issued
- `stall_cycles`  out  COUNT_WIDTH  stall statistic (see Configuration)

## Operation
- Reset values: state IDLE; all of `frame_busy`, `frame_end`, `stage_start`, `stage_valid`, `addr_*`, `stall_cycles` are 0. Internal `issued` and `done_seen` are also cleared.
- States: IDLE, RUN.
  - IDLE→RUN on `frame_start && !abort`. This loads the bases into `addr_*`, latches the count, and clears `issued`.
  - RUN→IDLE on the final drain advance or on `abort`.
- `done_seen[i]` is set by `stage_done[i]` while `stage_valid[i]` is high. `stage_done` on an unoccupied stage is ignored.
- `advance` = RUN && ∀i: (!stage_valid[i] || done_seen[i] || stage_done[i]). A `stage_done` arriving in the advance cycle counts.
- `issue` = `advance && issued < count`.
- On `advance`:
  - `stage_valid[0]` ← `issue`; `stage_valid[i]` ← `stage_valid[i-1]`.
  - All `done_seen` clear.
  - `stage_start[i]` = `advance && next stage_valid[i]`.
- On `issue`: `issued`++; `addr_vertex` += VERTEX_STRIDE; `addr_color` += COLOR_STRIDE, both after the current values are presented. Addresses wrap modulo 2^ADDR_WIDTH.
- Final drain: an advance that leaves next `stage_valid` all-zero with `issued == count` sets `frame_end` for the next cycle and returns to IDLE.
- `abort`:
  - Clears `stage_valid`, `done_seen`, `issued`; forces IDLE next cycle.
  - Suppresses `stage_start` and `frame_end` in its cycle; no `frame_end` is produced.
  - Wins over a simultaneous `frame_start` or advance.
- `frame_start` during RUN is ignored. Input changes during RUN have no effect, since values are latched on accept.

## Timing
- `frame_start` accepted in cycle T → RUN in T+1, `stage_start[0]` and `addr_*` = base in T+1.
- `count` = 0 → no `stage_start`; `frame_end` high in T+2.
- Zero-wait stages (`stage_done` same cycle as start): one advance per cycle; the frame of N triangles ends with `frame_end` at T+N+STAGES+1.
- `frame_start` can be accepted in the same cycle `frame_end` is high, because the state is already IDLE.

## Configuration
- `PIPE_STATS_EN` defined: `stall_cycles` counts RUN cycles with `advance` low. It clears on accepted `frame_start`, holds after `frame_end` or `abort`, and saturates at all-ones.
- `PIPE_STATS_EN` undefined: `stall_cycles` is tied to 0 and no counter logic is built.

## Structure
- Package `gpu_pipe_pkg`: `pipe_state_t` enum (IDLE, RUN) and the default stride constants.
- Sub-module `stage_tracker`: one per stage via generate. It holds `stage_valid` and `done_seen` and outputs its ready term for the `advance` AND-reduction.

## Test plan
- STAGES=3, count=1, immediate done → `stage_start` = 001, 010, 100 on consecutive cycles; `frame_end` at T+5.
- count=4, stage 1 done delayed 3 cycles per triangle → advance only after the delayed done; `stage_valid` never loses a triangle; exactly 4 pulses per stage.
- Bases 0x1000 and 0x2000, count=3 → `addr_vertex` 0x1000, 0x1012, 0x1024; `addr_color` 0x2000, 0x2002, 0x2004.
- count=0 → no `stage_start`; `frame_end` at T+2.
- `abort` mid-frame together with a `stage_done` → next cycle IDLE, `stage_valid`=0, no `frame_end`; a new `frame_start` then restarts from base.
- `PIPE_STATS_EN`, stage 2 stalls 5 cycles once → `stall_cycles` = 5 after `frame_end`.
